// File: rtl/tone_pkg.sv
// Shared types and constants for the square-wave tone generator.
// Holds the controller state encoding and the counter-width sizing helper.
package tone_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      RUN
   } state_t;

   localparam int HALF_PER_MIN = 2;
   localparam int FREQ_W       = 12;

   // Smallest width whose range exceeds half the clock rate.
   function automatic int cnt_w_min(input int clk_hz);
      int w;
      w = 1;
      while ((longint'(1) << w) <= longint'(clk_hz / 2)) w++;
      return w;
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per clock.
// A start pulse loads the operands; done pulses once the quotient is ready.
module seq_divider #(
   parameter int DVD_W = 26,
   parameter int DVS_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic [DVD_W-1:0] quotient,
   output logic             done
);

   localparam int STEP_W = $clog2(DVD_W + 1);

   logic [DVS_W-1:0]  rem;
   logic [DVS_W-1:0]  dvs;
   logic [STEP_W-1:0] steps;
   logic              running;
   logic [DVS_W:0]    trial;
   logic              fits;
   logic [DVS_W-1:0]  rem_nxt;

   // The remainder always stays below the divisor, so it fits back in DVS_W bits.
   always_comb begin
      trial   = {rem, quotient[DVD_W-1]};
      fits    = (trial >= {1'b0, dvs});
      rem_nxt = fits ? DVS_W'(trial - {1'b0, dvs}) : trial[DVS_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem      <= '0;
         dvs      <= '0;
         quotient <= '0;
         steps    <= '0;
         running  <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem      <= '0;
            dvs      <= divisor;
            quotient <= dividend;
            steps    <= STEP_W'(DVD_W);
            running  <= 1'b1;
         end else if (running) begin
            rem      <= rem_nxt;
            quotient <= {quotient[DVD_W-2:0], fits};
            steps    <= steps - STEP_W'(1);
            if (steps == STEP_W'(1)) begin
               running <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tone_square_gen.sv
// Square-wave tone generator driven by the keypad scanner's frequency word.
// Defining TONE_OCTAVE_EN adds an octave input that shifts the half-period down.
module tone_square_gen
   import tone_pkg::*;
#(
   parameter int CLK_HZ   = 100000000,
   parameter int FREQ_MIN = 20,
   parameter int CNT_W    = 26
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FREQ_W-1:0] freq,
   input  logic              mute,
`ifdef TONE_OCTAVE_EN
   input  logic [1:0]        octave,
`endif
   output logic              audio_out,
   output logic              tone_active,
   output logic              busy
);

   localparam int                HALF       = CLK_HZ / 2;
   localparam logic [CNT_W-1:0]  HALF_Q     = CNT_W'(HALF);
   localparam logic [CNT_W-1:0]  PER_MIN    = CNT_W'(HALF_PER_MIN);
   localparam logic [FREQ_W-1:0] FREQ_MIN_Q = FREQ_W'(FREQ_MIN);
   localparam int                CNT_W_MIN  = cnt_w_min(CLK_HZ);

   generate
      if (CNT_W < CNT_W_MIN) begin : g_cnt_w_check
         $error("tone_square_gen: CNT_W too small for CLK_HZ");
      end
   endgenerate

   state_t            state;
   logic [FREQ_W-1:0] cur_freq;
   logic [CNT_W-1:0]  half_per;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  base_q;
   logic [CNT_W-1:0]  pend_q;
   logic              pend_valid;
   logic              phase;
   logic              phase_nxt;
   logic              chg;
   logic              low;
   logic              div_start;
   logic              div_exit;
   logic              toggle;
   logic [CNT_W-1:0]  div_q;
   logic              div_done;
   logic [1:0]        shift;

`ifdef TONE_OCTAVE_EN
   assign shift = octave;
`else
   assign shift = 2'd0;
`endif

   // The clamp is applied after the octave shift so a shifted period never drops below 2.
   function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] q,
                                                    input logic [1:0]       sh);
      logic [CNT_W-1:0] s;
      s = q >> sh;
      return (s < PER_MIN) ? PER_MIN : s;
   endfunction

   seq_divider #(
      .DVD_W (CNT_W),
      .DVS_W (FREQ_W)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (HALF_Q),
      .divisor  (freq),
      .quotient (div_q),
      .done     (div_done)
   );

   // Frequency changes are only noticed outside DIV; the divider is never restarted mid-run.
   always_comb begin
      chg       = (state != DIV) && (freq != cur_freq);
      low       = (freq < FREQ_MIN_Q);
      div_start = chg && !low;
      div_exit  = (state == DIV) && div_done;
      toggle    = tone_active && (cnt == half_per - CNT_W'(1));
      phase_nxt = phase;
      if (toggle)
         phase_nxt = ~phase;
      if (div_exit && !tone_active)
         phase_nxt = 1'b1;
      if (chg && low)
         phase_nxt = 1'b0;
   end

   // Period updates land only on a toggle, so every half-cycle runs at one whole period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cur_freq    <= '0;
         half_per    <= '0;
         cnt         <= '0;
         base_q      <= '0;
         pend_q      <= '0;
         pend_valid  <= 1'b0;
         phase       <= 1'b0;
         audio_out   <= 1'b0;
         tone_active <= 1'b0;
         busy        <= 1'b0;
      end else begin
         phase     <= phase_nxt;
         audio_out <= phase_nxt & ~mute;

         if (toggle) begin
            cnt      <= '0;
            half_per <= eff_period(pend_valid ? pend_q : base_q, shift);
            if (pend_valid) begin
               base_q     <= pend_q;
               pend_valid <= 1'b0;
               if (state != DIV)
                  busy <= 1'b0;
            end
         end else if (tone_active) begin
            cnt <= cnt + CNT_W'(1);
         end

         if (div_exit) begin
            state <= RUN;
            if (tone_active) begin
               pend_q     <= div_q;
               pend_valid <= 1'b1;
            end else begin
               half_per    <= eff_period(div_q, shift);
               base_q      <= div_q;
               cnt         <= '0;
               tone_active <= 1'b1;
               busy        <= 1'b0;
            end
         end

         if (chg) begin
            cur_freq <= freq;
            if (low) begin
               state       <= IDLE;
               tone_active <= 1'b0;
               pend_valid  <= 1'b0;
               busy        <= 1'b0;
               cnt         <= '0;
            end else begin
               state <= DIV;
               busy  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tone_square_gen.sv
// Self-checking bench for tone_square_gen: a 1 MHz instance for the main scenarios
// and a 2 kHz instance where the half-period clamp is reachable with 12-bit inputs.
module tb_tone_square_gen;

   localparam int CLK1 = 1000000;
   localparam int CW1  = 20;
   localparam int CLK2 = 2000;
   localparam int CW2  = 11;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic [11:0] freq1 = '0;
   logic [11:0] freq2 = '0;
   logic        mute1 = 1'b0;
   logic        mute2 = 1'b0;
   logic        audio1, act1, busy1;
   logic        audio2, act2, busy2;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   tone_square_gen #(.CLK_HZ(CLK1), .FREQ_MIN(20), .CNT_W(CW1)) dut (
      .clk         (clk),
      .rst         (rst),
      .freq        (freq1),
      .mute        (mute1),
`ifdef TONE_OCTAVE_EN
      .octave      (2'b00),
`endif
      .audio_out   (audio1),
      .tone_active (act1),
      .busy        (busy1)
   );

   tone_square_gen #(.CLK_HZ(CLK2), .FREQ_MIN(20), .CNT_W(CW2)) dut2 (
      .clk         (clk),
      .rst         (rst),
      .freq        (freq2),
      .mute        (mute2),
`ifdef TONE_OCTAVE_EN
      .octave      (2'b00),
`endif
      .audio_out   (audio2),
      .tone_active (act2),
      .busy        (busy2)
   );

   // Reference half-period: floor(HALF/freq), never below 2.
   function automatic int exp_half(input int clk_hz, input int f);
      int q;
      q = (clk_hz / 2) / f;
      return (q < 2) ? 2 : q;
   endfunction

   function automatic logic aud(input bit s);
      return s ? audio2 : audio1;
   endfunction

   function automatic logic bsy(input bit s);
      return s ? busy2 : busy1;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic next_toggle(input bit s, input int limit, output int waited);
      logic prev;
      prev   = aud(s);
      waited = 0;
      while (aud(s) === prev && waited < limit) begin
         tick(1);
         waited++;
      end
      if (aud(s) === prev) waited = -1;
   endtask

   task automatic wait_not_busy(input bit s, input int limit, output int waited);
      waited = 0;
      while (bsy(s) !== 1'b0 && waited < limit) begin
         tick(1);
         waited++;
      end
      if (bsy(s) !== 1'b0) waited = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      checks++;
      if ({audio1, act1, busy1} !== 3'b000) begin
         fails++;
         $display("[TB] FAIL reset_dut1: got %b want 000", {audio1, act1, busy1});
      end
      checks++;
      if ({audio2, act2, busy2} !== 3'b000) begin
         fails++;
         $display("[TB] FAIL reset_dut2: got %b want 000", {audio2, act2, busy2});
      end
      rst = 1'b0;
      tick(3);
      checks++;
      if ({audio1, act1, busy1} !== 3'b000) begin
         fails++;
         $display("[TB] FAIL idle_after_reset: got %b want 000", {audio1, act1, busy1});
      end
   endtask

   task automatic test_latency();
      int w;
      freq1 = 12'd440;
      tick(CW1 + 1);
      checks++;
      if ({act1, busy1} !== 2'b01) begin
         fails++;
         $display("[TB] FAIL latency_early: act/busy got %b want 01", {act1, busy1});
      end
      tick(1);
      checks++;
      if ({audio1, act1, busy1} !== 3'b110) begin
         fails++;
         $display("[TB] FAIL latency_rise: got %b want 110", {audio1, act1, busy1});
      end
      for (int i = 0; i < 3; i++) begin
         next_toggle(0, 3000, w);
         checks++;
         if (w != exp_half(CLK1, 440)) begin
            fails++;
            $display("[TB] FAIL half_440[%0d]: got %0d want %0d", i, w, exp_half(CLK1, 440));
         end
      end
   endtask

   task automatic test_retune();
      int w;
      tick(100);
      freq1 = 12'd523;
      next_toggle(0, 3000, w);
      checks++;
      if (100 + w != exp_half(CLK1, 440)) begin
         fails++;
         $display("[TB] FAIL retune_current_half: got %0d want %0d", 100 + w, exp_half(CLK1, 440));
      end
      checks++;
      if (busy1 !== 1'b0) begin
         fails++;
         $display("[TB] FAIL retune_busy_after_apply: got %b want 0", busy1);
      end
      for (int i = 0; i < 2; i++) begin
         next_toggle(0, 3000, w);
         checks++;
         if (w != exp_half(CLK1, 523)) begin
            fails++;
            $display("[TB] FAIL half_523[%0d]: got %0d want %0d", i, w, exp_half(CLK1, 523));
         end
      end
   endtask

   task automatic test_silence();
      int w;
      freq1 = 12'd0;
      tick(1);
      checks++;
      if ({audio1, act1, busy1} !== 3'b000) begin
         fails++;
         $display("[TB] FAIL silence: got %b want 000", {audio1, act1, busy1});
      end
      freq1 = 12'd262;
      tick(CW1 + 2);
      checks++;
      if (act1 !== 1'b1) begin
         fails++;
         $display("[TB] FAIL restart_active: got %b want 1", act1);
      end
      for (int i = 0; i < 2; i++) begin
         next_toggle(0, 5000, w);
         checks++;
         if (w != exp_half(CLK1, 262)) begin
            fails++;
            $display("[TB] FAIL half_262[%0d]: got %0d want %0d", i, w, exp_half(CLK1, 262));
         end
      end
   endtask

   task automatic test_div_window();
      int w;
      freq1 = 12'd0;
      tick(2);
      freq1 = 12'd440;
      tick(5);
      freq1 = 12'd349;
      tick(5);
      freq1 = 12'd294;
      tick(CW1 + 2 - 10);
      checks++;
      if ({audio1, act1} !== 2'b11) begin
         fails++;
         $display("[TB] FAIL window_first_load: got %b want 11", {audio1, act1});
      end
      tick(2);
      checks++;
      if (busy1 !== 1'b1) begin
         fails++;
         $display("[TB] FAIL window_busy: got %b want 1", busy1);
      end
      wait_not_busy(0, 3000, w);
      checks++;
      if (w != exp_half(CLK1, 440) - 2 || audio1 !== 1'b0) begin
         fails++;
         $display("[TB] FAIL window_apply: busy fell after %0d with audio %b, want %0d with 0",
                  w, audio1, exp_half(CLK1, 440) - 2);
      end
      for (int i = 0; i < 2; i++) begin
         next_toggle(0, 4000, w);
         checks++;
         if (w != exp_half(CLK1, 294)) begin
            fails++;
            $display("[TB] FAIL half_294[%0d]: got %0d want %0d", i, w, exp_half(CLK1, 294));
         end
      end
   endtask

   task automatic test_mute();
      int   w;
      int   bad;
      int   per;
      int   k;
      logic l0;
      logic lvl;
      per   = exp_half(CLK1, 440);
      freq1 = 12'd440;
      tick(1);
      wait_not_busy(0, 5000, w);
      checks++;
      if (w < 0) begin
         fails++;
         $display("[TB] FAIL mute_setup: busy stuck, got %0d want >=0", w);
      end
      l0 = audio1;
      tick(10);
      mute1 = 1'b1;
      bad   = 0;
      for (int i = 0; i < 3000; i++) begin
         tick(1);
         if (audio1 !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         fails++;
         $display("[TB] FAIL mute_hold: got %0d high cycles want 0", bad);
      end
      mute1 = 1'b0;
      tick(1);
      k   = 3011;
      lvl = l0 ^ logic'((k / per) % 2);
      checks++;
      if (audio1 !== lvl) begin
         fails++;
         $display("[TB] FAIL unmute_level: got %b want %b", audio1, lvl);
      end
      next_toggle(0, 3000, w);
      checks++;
      if (k + w != ((k / per) + 1) * per) begin
         fails++;
         $display("[TB] FAIL unmute_grid: got %0d want %0d", k + w, ((k / per) + 1) * per);
      end
   endtask

   task automatic test_reset_mid_div();
      int w;
      freq1 = 12'd262;
      tick(3);
      freq1 = 12'd440;
      tick(3);
      checks++;
      if ({act1, busy1} !== 2'b11) begin
         fails++;
         $display("[TB] FAIL mid_div_setup: act/busy got %b want 11", {act1, busy1});
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({audio1, act1, busy1} !== 3'b000) begin
         fails++;
         $display("[TB] FAIL async_reset: got %b want 000", {audio1, act1, busy1});
      end
      tick(2);
      rst = 1'b0;
      tick(CW1 + 1);
      checks++;
      if (act1 !== 1'b0) begin
         fails++;
         $display("[TB] FAIL post_reset_early: got %b want 0", act1);
      end
      tick(1);
      checks++;
      if ({audio1, act1} !== 2'b11) begin
         fails++;
         $display("[TB] FAIL post_reset_rise: got %b want 11", {audio1, act1});
      end
      for (int i = 0; i < 2; i++) begin
         next_toggle(0, 3000, w);
         checks++;
         if (w != exp_half(CLK1, 440)) begin
            fails++;
            $display("[TB] FAIL post_reset_half[%0d]: got %0d want %0d", i, w, exp_half(CLK1, 440));
         end
      end
   endtask

   task automatic test_random();
      int          w;
      int          w1;
      int          w2;
      logic [11:0] f;
      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin
            f = 12'd4095;
         end else begin
            f = 12'($urandom_range(400, 4095));
            while (f == freq1) f = 12'($urandom_range(400, 4095));
         end
         freq1 = f;
         tick(1);
         wait_not_busy(0, 4000, w);
         next_toggle(0, 3000, w1);
         next_toggle(0, 3000, w2);
         checks++;
         if (w < 0 || w1 != exp_half(CLK1, int'(f)) || w2 != exp_half(CLK1, int'(f))) begin
            fails++;
            $display("[TB] FAIL random_f%0d: halves got %0d,%0d (wait %0d) want %0d",
                     f, w1, w2, w, exp_half(CLK1, int'(f)));
         end
      end
   endtask

   task automatic test_boundaries();
      int w;
      int w1;
      int w2;
      int flist[5] = '{20, 600, 1000, 4095, 300};
      freq2 = 12'd19;
      tick(CW2 + 4);
      checks++;
      if ({audio2, act2, busy2} !== 3'b000) begin
         fails++;
         $display("[TB] FAIL below_min: got %b want 000", {audio2, act2, busy2});
      end
      foreach (flist[i]) begin
         freq2 = 12'(flist[i]);
         tick(1);
         wait_not_busy(1, 500, w);
         next_toggle(1, 500, w1);
         next_toggle(1, 500, w2);
         checks++;
         if (w < 0 || w1 != exp_half(CLK2, flist[i]) || w2 != exp_half(CLK2, flist[i])) begin
            fails++;
            $display("[TB] FAIL boundary_f%0d: halves got %0d,%0d (wait %0d) want %0d",
                     flist[i], w1, w2, w, exp_half(CLK2, flist[i]));
         end
      end
   endtask

   initial begin : watchdog
      #3000000;
      $display("[TB] FAIL watchdog: time limit reached after %0d checks", checks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_latency();
      test_retune();
      test_silence();
      test_div_window();
      test_mute();
      test_reset_mid_div();
      test_random();
      test_boundaries();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
